// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte clients.
// Optional tx_done_tick watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           din,
    input  logic                        tx_done_tick,
    output logic                        err_tick
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t                          state_q, state_d;
    logic [ID_W-1:0]                 grant_id_q, grant_id_d;
    logic [ID_W-1:0]                 last_grant_q, last_grant_d;
    logic [DATA_W-1:0]               din_q, din_d;
    logic [NUM_REQ-1:0]              req_ack_q, req_ack_d;
    logic                            tx_start_q, tx_start_d;
    logic                            busy_q, busy_d;
    logic                            err_tick_q, err_tick_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]  data_arr;
    logic [ID_W:0]                   cand;
    logic [ID_W-1:0]                 winner;
    logic                            found;

    assign data_arr = req_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

    // Scan last_grant+1, last_grant+2, ... (mod NUM_REQ); first hit wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!found && req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        din_d        = din_q;
        req_ack_d    = '0;
        tx_start_d   = 1'b0;
        err_tick_d   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: if (found) begin
                grant_id_d = winner;
                din_d      = data_arr[winner];
                tx_start_d = 1'b1;
                state_d    = START;
            end
            START: begin
                state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // Completion beats a simultaneous timeout.
                if (tx_done_tick) begin
                    req_ack_d[grant_id_q] = 1'b1;
                    state_d               = DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
                    err_tick_d   = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                last_grant_d = grant_id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ-1);
            din_q        <= '0;
            req_ack_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_tick_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            din_q        <= din_d;
            req_ack_q    <= req_ack_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            err_tick_q   <= err_tick_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ack  = req_ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign tx_start = tx_start_q;
    assign din      = din_q;
    assign err_tick = err_tick_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scoreboard of expected grants checked at each tx_start.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = 32'h4332_2110;
    logic [3:0]  req_ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_start;
    logic [7:0]  din;
    logic        tx_done_tick = 1'b0;
    logic        err_tick;

    int checks = 0;
    int failures = 0;

    typedef struct { int id; logic [7:0] data; } exp_t;
    exp_t sb[$];

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ack(req_ack),
        .busy(busy), .grant_id(grant_id), .tx_start(tx_start), .din(din),
        .tx_done_tick(tx_done_tick), .err_tick(err_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] data);
        exp_t e;
        e.id = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_start(output exp_t e);
        int n = 0;
        while (tx_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", tx_start, 1);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) e = sb.pop_front();
        else begin e.id = 0; e.data = 8'h00; end
        chk("din", din, e.data);
        chk("grant_id", grant_id, e.id);
        chk("busy_start", busy, 1);
    endtask

    task automatic finish_xfer(input exp_t e, input int lat, input logic [3:0] drop);
        int bad = 0;
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || req_ack !== 4'b0 || busy !== 1'b1) bad++;
        end
        chk("wait_quiet", bad, 0);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("ack", req_ack, 32'(4'b1 << e.id));
        chk("err_tick_low", err_tick, 0);
        req = req & ~drop;
        @(negedge clk);
        chk("ack_cleared", req_ack, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        exp_t e;
        int n, bad;
        // Reset values
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_din", din, 0);
        chk("rst_err_tick", err_tick, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single client, byte B2, latency of one cycle to tx_start
        req_data[7:0] = 8'hB2;
        req = 4'b0001;
        push(0, 8'hB2);
        @(negedge clk);
        chk("t1_latency", tx_start, 1);
        wait_start(e);
        finish_xfer(e, 10, 4'b0001);

        // All clients from fresh reset: order 0,1,2,3,0
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_data = 32'h4332_2110;
        req = 4'b1111;
        push(0, 8'h10); push(1, 8'h21); push(2, 8'h32); push(3, 8'h43); push(0, 8'h10);
        for (int k = 0; k < 5; k++) begin
            wait_start(e);
            finish_xfer(e, 10, (k == 4) ? 4'b1111 : 4'b0000);
        end

        // Wrap-around: after client 1, 0011 grants 0 then 1
        req = 4'b0010;
        push(1, 8'h21);
        wait_start(e);
        finish_xfer(e, 6, 4'b0010);
        req = 4'b0011;
        push(0, 8'h10); push(1, 8'h21);
        wait_start(e);
        finish_xfer(e, 6, 4'b0001);
        wait_start(e);
        finish_xfer(e, 6, 4'b0010);

        // Spurious ticks in IDLE and START are ignored
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("idle_tick_busy", busy, 0);
        chk("idle_tick_ack", req_ack, 0);
        req = 4'b0100;
        push(2, 8'h32);
        wait_start(e);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("start_tick_ack", req_ack, 0);
        chk("start_tick_busy", busy, 1);
        finish_xfer(e, 9, 4'b0100);

        // Reset in WAIT aborts without ack; client 2 granted after release
        req = 4'b0001;
        push(0, 8'h10);
        wait_start(e);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack", req_ack, 0);
        chk("midrst_grant", grant_id, 0);
        @(negedge clk);
        reset = 1'b1;
        req = 4'b0100;
        push(2, 8'h32);
        @(negedge clk);
        chk("rst_release_latency", tx_start, 1);
        wait_start(e);
        finish_xfer(e, 10, 4'b0100);

`ifdef UART_ARB_TIMEOUT_EN
        // Timeout: err_tick 16 cycles after WAIT entry, no ack, next client next
        req = 4'b0001;
        push(0, 8'h10);
        wait_start(e);
        n = 0;
        bad = 0;
        while (err_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (req_ack !== 4'b0) bad++;
        end
        chk("to_cycles", n, 17);
        chk("to_no_ack", bad, 0);
        chk("to_busy", busy, 0);
        req = 4'b0011;
        push(1, 8'h21);
        @(negedge clk);
        chk("to_err_pulse", err_tick, 0);
        wait_start(e);
        finish_xfer(e, 5, 4'b0011);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte-producing clients. It sits between the client logic and the uart core's tx_start/din/tx_done_tick interface. It accepts one byte per grant, pulses tx_start to the transmitter, waits for tx_done_tick, then acknowledges the winning client. Only one byte is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesting clients (2..16)
DATA_W, 8, byte width, matches the uart din width
TIMEOUT_CYC, 200000, maximum cycles to wait for tx_done_tick (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NUM_REQ  per-client request level; held high until the matching req_ack
req_data  input  NUM_REQ*DATA_W  client i byte in bits [i*DATA_W +: DATA_W]; stable while req[i]=1
req_ack  output  NUM_REQ  one-cycle pulse to the client whose byte completed
busy  output  1  high whenever the FSM is not in IDLE
grant_id  output  clog2(NUM_REQ)  index of the current or last granted client
tx_start  output  1  one-cycle start pulse to the uart transmitter
din  output  DATA_W  byte to the uart transmitter; held stable from START through WAIT
tx_done_tick  input  1  one-cycle completion tick from the uart transmitter
err_tick  output  1  one-cycle timeout pulse; tied to 0 without the macro

Behaviour:
- Reset (reset=0, async): state=IDLE; tx_start=0, din=0, req_ack=0, busy=0, grant_id=0, err_tick=0; last_grant=NUM_REQ-1, so client 0 has first priority after reset.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE, when req != 0:
  - Select the first asserted req scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Register the winner into grant_id and its byte into din.
  - Go to START.
- IDLE, when req == 0: stay in IDLE.
- START: tx_start=1 for exactly one cycle; go to WAIT.
- WAIT: tx_start=0; din held. On tx_done_tick=1, go to DONE.
- DONE:
  - req_ack[grant_id]=1 for one cycle; last_grant<=grant_id; go to IDLE.
  - A new arbitration happens in the following IDLE cycle, so back-to-back grants have one idle cycle between them.
- Latency: req rising edge sampled in IDLE at edge N gives tx_start high in cycle N+1. tx_done_tick at edge M gives req_ack high in cycle M+1.
- Fairness: a client continuously requesting waits at most NUM_REQ-1 other transfers.
- tx_done_tick outside WAIT (including in START) is ignored.
- req[i] dropped after grant: the transfer still completes and req_ack[i] is still pulsed. The requester must tolerate this.
- req[i] may be re-asserted in the cycle after its ack. It is then lowest priority relative to the other clients.
- Simultaneous req on all clients after reset: grant order is 0,1,2,...,NUM_REQ-1,0,...
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values; no ack is issued. The uart core is reset by the same signal.
- busy=1 in START, WAIT and DONE.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT_CYC-1 without tx_done_tick, the FSM goes to IDLE, pulses err_tick for one cycle, and updates last_grant<=grant_id.
  - No req_ack is issued; the client may retry.
  - If tx_done_tick arrives in the same cycle as the timeout, completion wins: DONE is entered and there is no err_tick.
- Undefined: no counter is present; WAIT waits indefinitely; err_tick is constant 0.

Test Plan:
- Reset release, then req=4'b0001, req_data[7:0]=8'hB2, and the uart model returns tx_done_tick 10 cycles after tx_start -> tx_start pulses once with din=8'hB2, grant_id=0, then req_ack=4'b0001 one cycle after the tick; busy=0 afterwards.
- req=4'b1111 held with bytes 8'h10,8'h21,8'h32,8'h43 -> tx_start/din sequence 10,21,32,43,10; each req_ack bit pulses in order 0,1,2,3; exactly one tx_start per tx_done_tick.
- After client 1 is served, req=4'b0011 -> client 0 is granted next (wrap-around of the round-robin pointer); then client 1.
- Spurious tx_done_tick in IDLE and in START -> no ack and no state change; the transfer completes only on a tick seen in WAIT.
- reset=0 asserted in WAIT -> tx_start=0, busy=0, req_ack=0 immediately; after release with req=4'b0100, client 2 is granted and tx_start follows one cycle later.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no tx_done_tick -> err_tick pulses 16 cycles after WAIT entry, no req_ack, and the next grant goes to the next client.
